// File: rtl/channel_uploader_if.sv
// Channel-side read port and transmitter byte stream of the channel uploader.
interface channel_uploader_if;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned COUNT_W = 16;

  logic               enable;
  logic               available;
  logic               o_read;
  logic [WORD_W-1:0]  i_data;
  logic [BYTE_W-1:0]  tx_data;
  logic               tx_valid;
  logic               tx_ready;
  logic               busy;
  logic [COUNT_W-1:0] word_count;

  modport master (
    input  enable, available, i_data, tx_ready,
    output o_read, tx_data, tx_valid, busy, word_count
  );

  modport slave (
    output enable, available, i_data, tx_ready,
    input  o_read, tx_data, tx_valid, busy, word_count
  );
endinterface

// File: rtl/channel_uploader.sv
// Channel uploader: pops 32-bit words from a capture channel FIFO with an
// edge-triggered read strobe and streams them out as bytes on valid/ready.
// Optional macro CHANNEL_UPLOADER_SYNC_HEADER_EN prefixes every word with 0xA5.
module channel_uploader #(
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned LSB_FIRST    = 1
) (
  input  logic               i_clk,
  input  logic               _mrst,
  channel_uploader_if.master bus
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned COUNT_W = 16;
`ifdef CHANNEL_UPLOADER_SYNC_HEADER_EN
  localparam int unsigned NUM_BYTES = 5;
  localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hA5;
`else
  localparam int unsigned NUM_BYTES = 4;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    SEND = 3'd3,
    GAP  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WORD_W-1:0]  shreg_q, shreg_d;
  logic [WORD_W-1:0]  shifted;
  logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
  logic [COUNT_W-1:0] wc_q, wc_d;
  logic               o_read_q, o_read_d;
  logic               tx_valid_q, tx_valid_d;
  logic               busy_q, busy_d;

  // Byte at the transmit end of the shift register.
  function automatic logic [BYTE_W-1:0] head(input logic [WORD_W-1:0] w);
    return (LSB_FIRST != 0) ? w[7:0] : w[31:24];
  endfunction

  // Shift the next byte into the transmit position.
  function automatic logic [WORD_W-1:0] shift(input logic [WORD_W-1:0] w);
    return (LSB_FIRST != 0) ? {8'h00, w[31:8]} : {w[23:0], 8'h00};
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    tx_data_d = tx_data_q;
    wc_d      = wc_q;
    shifted   = shift(shreg_q);

    case (state_q)
      IDLE: begin
        if (bus.enable && bus.available) begin
          state_d = REQ;
        end
      end
      REQ: begin
        cnt_d   = CNT_W'(READ_LATENCY);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Last wait cycle: the FIFO word is valid on i_data now.
        if (cnt_q <= CNT_W'(1)) begin
          shreg_d = bus.i_data;
          idx_d   = '0;
`ifdef CHANNEL_UPLOADER_SYNC_HEADER_EN
          tx_data_d = SYNC_BYTE;
`else
          tx_data_d = head(bus.i_data);
`endif
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.tx_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            wc_d    = wc_q + COUNT_W'(1);
            state_d = GAP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
`ifdef CHANNEL_UPLOADER_SYNC_HEADER_EN
            // After the header the first data byte is already in place.
            if (idx_q == '0) begin
              tx_data_d = head(shreg_q);
            end else begin
              shreg_d   = shifted;
              tx_data_d = head(shifted);
            end
`else
            shreg_d   = shifted;
            tx_data_d = head(shifted);
`endif
          end
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    o_read_d   = (state_d == REQ);
    tx_valid_d = (state_d == SEND);
    busy_d     = (state_d != IDLE);
  end

  // State and registered outputs; synchronous reset drops any word in flight.
  always_ff @(posedge i_clk) begin
    if (!_mrst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shreg_q    <= '0;
      tx_data_q  <= '0;
      wc_q       <= '0;
      o_read_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      tx_data_q  <= tx_data_d;
      wc_q       <= wc_d;
      o_read_q   <= o_read_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.o_read     = o_read_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.busy       = busy_q;
  assign bus.word_count = wc_q;

endmodule

// File: tb/tb_channel_uploader.sv
// Self-checking bench for channel_uploader: channel FIFO model, randomized
// traffic and a cycle-level reference model of the byte stream.
`timescale 1ns/1ps
module tb_channel_uploader;

  localparam int unsigned READ_LATENCY = 2;
  localparam int unsigned LSB_FIRST    = 1;
`ifdef CHANNEL_UPLOADER_SYNC_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int NB = 4 + HDR;

  logic i_clk = 1'b0;
  logic _mrst;

  channel_uploader_if bus ();

  channel_uploader #(
    .READ_LATENCY(READ_LATENCY),
    .LSB_FIRST   (LSB_FIRST)
  ) dut (
    .i_clk(i_clk),
    ._mrst(_mrst),
    .bus  (bus)
  );

  always #5 i_clk = ~i_clk;

  // Shared stimulus state (written by the driver only).
  logic [31:0] words[$];
  int          chan_rd   = 0;
  int          dcnt      = -1;
  logic [31:0] popped    = '0;
  logic        or_prev_d = 1'b0;
  int          timeouts  = 0;
  int          lit_id    = 0;
  bit          tb_done   = 1'b0;

  // Checker / model state (written by the compare process only).
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          lit_done = 0;
  bit          rst_p = 1'b0, en_p = 1'b0, av_p = 1'b0, busy_p = 1'b0;
  bit          active = 1'b0, gap_now = 1'b0, gap_nx = 1'b0;
  bit          oread_exp, busy_exp, tv_exp;
  int          send_start = 0;
  int          left = 0;
  int          mdl_rd = 0;
  logic [31:0] w;
  logic [7:0]  expq[$];
  logic [7:0]  hs_log[$];
  logic [15:0] wc_exp = '0;
  int          or_count = 0;
  int          or_rise = -1, tv_rise = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Compare four logged handshake bytes of one word against literal values.
  task automatic lit_bytes(input string name, input int base,
                           input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] e [4];
    e = '{b0, b1, b2, b3};
    if (HDR != 0) begin
      if (base < hs_log.size()) chk({name, "_hdr"}, 32'(hs_log[base]), 32'h0000_00A5);
      else chk({name, "_hdr_missing"}, 32'hFFFF_FFFF, 32'h0000_00A5);
    end
    for (int k = 0; k < 4; k++) begin
      if (base + HDR + k < hs_log.size()) chk(name, 32'(hs_log[base + HDR + k]), 32'(e[k]));
      else chk({name, "_missing"}, 32'hFFFF_FFFF, 32'(e[k]));
    end
  endtask

  // Reference model and per-cycle comparison, sampled mid-cycle.
  always @(negedge i_clk) begin
    cyc++;
    oread_exp = 1'b0;
    if (!rst_p) begin
      active = 1'b0;
      gap_nx = 1'b0;
      left   = 0;
      expq.delete();
      wc_exp = '0;
    end else if (!busy_p && en_p && av_p) begin
      oread_exp  = 1'b1;
      active     = 1'b1;
      send_start = cyc + int'(READ_LATENCY) + 1;
      left       = NB;
      w = (mdl_rd < words.size()) ? words[mdl_rd] : 32'h0;
      mdl_rd++;
      if (HDR != 0) expq.push_back(8'hA5);
      for (int k = 0; k < 4; k++) begin
        int sh;
        sh = (LSB_FIRST != 0) ? 8 * k : 8 * (3 - k);
        expq.push_back(8'(w >> sh));
      end
    end
    gap_now  = gap_nx;
    gap_nx   = 1'b0;
    busy_exp = active || gap_now;
    tv_exp   = active && (cyc >= send_start);

    chk("o_read", 32'(bus.o_read), 32'(oread_exp));
    chk("busy", 32'(bus.busy), 32'(busy_exp));
    chk("tx_valid", 32'(bus.tx_valid), 32'(tv_exp));
    chk("word_count", 32'(bus.word_count), 32'(wc_exp));
    if (!rst_p) chk("tx_data_reset", 32'(bus.tx_data), 32'h0);
    if (tv_exp && expq.size() > 0) begin
      chk("tx_data", 32'(bus.tx_data), 32'(expq[0]));
      if (bus.tx_ready) begin
        void'(expq.pop_front());
        left--;
        if (left == 0) begin
          active = 1'b0;
          gap_nx = 1'b1;
          wc_exp = wc_exp + 16'd1;
        end
      end
    end

    if (bus.tx_valid && bus.tx_ready) hs_log.push_back(bus.tx_data);
    if (bus.o_read) or_count++;
    if (or_rise < 0 && bus.o_read) or_rise = cyc;
    if (tv_rise < 0 && bus.tx_valid) tv_rise = cyc;

    rst_p  = _mrst;
    en_p   = bus.enable;
    av_p   = bus.available;
    busy_p = busy_exp;

    if (lit_id != lit_done) begin
      case (lit_id)
        1: begin
          chk("idle_oread_pulses", 32'(or_count), 32'd0);
          chk("idle_word_count", 32'(bus.word_count), 32'd0);
          chk("idle_busy", 32'(bus.busy), 32'd0);
          chk("idle_tx_valid", 32'(bus.tx_valid), 32'd0);
        end
        2: begin
          lit_bytes("word1_bytes", 0, 8'h44, 8'h33, 8'h22, 8'h11);
          chk("first_latency", 32'(tv_rise - or_rise), 32'd3);
          chk("word1_count", 32'(bus.word_count), 32'd1);
        end
        3: begin
          lit_bytes("word2_bytes", NB, 8'h44, 8'h33, 8'h22, 8'h11);
          chk("word2_count", 32'(bus.word_count), 32'd2);
        end
        4: begin
          lit_bytes("word5_bytes", 4 * NB, 8'h03, 8'h00, 8'h00, 8'hA0);
          chk("three_word_count", 32'(bus.word_count), 32'd5);
          chk("three_word_pulses", 32'(or_count), 32'd5);
        end
        5: begin
          chk("en_drop_count", 32'(bus.word_count), 32'd6);
          chk("en_drop_pulses", 32'(or_count), 32'd6);
        end
        6: begin
          chk("rst_word_count", 32'(bus.word_count), 32'd0);
          chk("rst_busy", 32'(bus.busy), 32'd0);
          chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
          chk("rst_o_read", 32'(bus.o_read), 32'd0);
          chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        end
        7: begin
          lit_bytes("resume_bytes", hs_log.size() - NB, 8'h0D, 8'hF0, 8'hFE, 8'hCA);
          chk("resume_count", 32'(bus.word_count), 32'd1);
        end
        default: ;
      endcase
      lit_done = lit_id;
    end

    if (tb_done) begin
      chk("timeouts", 32'(timeouts), 32'd0);
      chk("drained_busy", 32'(bus.busy), 32'd0);
      chk("drained_fifo", 32'(words.size() - chan_rd), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  // One clock of channel FIFO behaviour: pop on o_read rising edge, word
  // valid on i_data exactly READ_LATENCY cycles later, noise otherwise.
  task automatic step();
    logic [31:0] d;
    @(posedge i_clk);
    #1;
    d = $urandom;
    if (dcnt > 0) begin
      dcnt = dcnt - 1;
      if (dcnt == 0) begin
        d    = popped;
        dcnt = -1;
      end
    end
    if (bus.o_read && !or_prev_d) begin
      if (chan_rd < words.size()) begin
        popped = words[chan_rd];
        chan_rd++;
      end else begin
        popped = 32'hDEAD_BEEF;
      end
      dcnt = int'(READ_LATENCY);
    end
    or_prev_d     = bus.o_read;
    bus.i_data    = d;
    bus.available = (chan_rd < words.size());
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Directed phases followed by randomized traffic.
  initial begin
    logic [3:0] pat;
    bit         seen;
    pat = 4'b1001;
    _mrst = 1'b0;
    bus.enable    = 1'b1;
    bus.available = 1'b0;
    bus.i_data    = '0;
    bus.tx_ready  = 1'b1;
    steps(3);
    _mrst = 1'b1;
    steps(20);
    lit_id = 1;

    words.push_back(32'h1122_3344);
    steps(20);
    lit_id = 2;

    words.push_back(32'h1122_3344);
    for (int i = 0; i < 30; i++) begin
      step();
      bus.tx_ready = pat[3 - (i % 4)];
    end
    bus.tx_ready = 1'b1;
    steps(5);
    lit_id = 3;

    words.push_back(32'hA000_0001);
    words.push_back(32'hA000_0002);
    words.push_back(32'hA000_0003);
    steps(40);
    lit_id = 4;

    words.push_back(32'h5555_0001);
    words.push_back(32'h5555_0002);
    words.push_back(32'h5555_0003);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step();
      if (bus.tx_valid && bus.tx_ready) seen = 1'b1;
    end
    if (!seen) timeouts++;
    step();
    bus.enable = 1'b0;
    steps(40);
    lit_id = 5;
    bus.enable = 1'b1;
    steps(40);

    words.push_back(32'h7777_8888);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (bus.o_read) seen = 1'b1;
    end
    if (!seen) timeouts++;
    step();
    _mrst = 1'b0;
    step();
    _mrst = 1'b1;
    lit_id = 6;
    words.push_back(32'hCAFE_F00D);
    steps(20);
    lit_id = 7;

    for (int i = 0; i < 600; i++) begin
      step();
      if ((words.size() - chan_rd) < 4 && $urandom_range(5, 0) == 0) words.push_back($urandom);
      bus.enable   = ($urandom_range(7, 0) != 0);
      bus.tx_ready = ($urandom_range(2, 0) != 0);
      _mrst        = ($urandom_range(199, 0) != 0);
    end
    _mrst        = 1'b1;
    bus.enable   = 1'b1;
    bus.tx_ready = 1'b1;
    steps(80);
    tb_done = 1'b1;
    repeat (10) @(posedge i_clk);
    $display("FAIL end_of_test not reached errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/channel_uploader.md
Name: channel_uploader

Overview:
- Drains 32-bit sample words from one capture channel's output FIFO. Pops the FIFO with the channel's edge-triggered read strobe and splits each word into 4 bytes.
- Presents the bytes on a valid/ready byte stream that feeds the host serial transmitter.
- Sits directly downstream of the channel block. Connects to its read, o_data and available ports.

Parameters:
- READ_LATENCY, 2, cycles from the o_read rising edge to a valid i_data word (edge detector + FIFO q register); range 1..15.
- LSB_FIRST, 1, 1 = byte 0 is i_data[7:0]; 0 = byte 0 is i_data[31:24].

Ports:
- i_clk  input  1  system clock; all logic on its rising edge.
- _mrst  input  1  synchronous active-low reset.
- enable  input  1  allows new words to be fetched.
- available  input  1  channel FIFO non-empty.
- o_read  output  1  read strobe to the channel; the channel pops one word per rising edge.
- i_data  input  32  channel FIFO output word.
- tx_data  output  8  byte to transmitter.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  transmitter accepts the byte when tx_valid & tx_ready.
- busy  output  1  high in any state other than IDLE.
- word_count  output  16  words fully transmitted since reset.

Behaviour:
- Reset (_mrst low at a clock edge): state=IDLE; o_read=0, tx_valid=0, tx_data=0, busy=0, word_count=0, latency counter=0, byte index=0.
  - Reset mid-operation drops any word in flight, including one already popped.
- FSM states: IDLE, REQ, WAIT, SEND, GAP.
- IDLE: if enable & available, go to REQ next cycle; otherwise stay.
- REQ: o_read=1 for exactly 1 cycle; load latency counter with READ_LATENCY; go to WAIT.
- WAIT: o_read=0; decrement the counter each cycle.
  - When the counter reaches 0, capture i_data into a 32-bit shift register, set byte index=0, and go to SEND.
  - First tx_valid is asserted READ_LATENCY+1 cycles after o_read rises.
- SEND: tx_valid=1 and tx_data=selected byte (order per LSB_FIRST).
  - tx_data stays stable while tx_valid & ~tx_ready.
  - On each handshake, advance the byte index. On the handshake of byte 3, deassert tx_valid next cycle, increment word_count, and go to GAP.
  - Back-to-back handshakes allowed: 4 bytes in 4 cycles when tx_ready is held high.
- GAP: 1 cycle with o_read=0, so that o_read returns low (needed for the next edge) and available settles after the pop. Then go to IDLE.
- Minimum word period with tx_ready=1: 1 (IDLE) + 1 (REQ) + READ_LATENCY + 4 + 1 (GAP) cycles.
- enable deasserted mid-word: the current word completes; no new fetch starts. enable is sampled only in IDLE.
- available dropping after REQ: ignored; the word is already popped.
- available high while the channel is still sampling: the block drains concurrently; no interaction with o_run.
- word_count wraps from 0xFFFF to 0x0000 without a flag.
- o_read never asserts while busy with a prior word, so at most 1 word is in flight.

Optional Feature:
- Macro: CHANNEL_UPLOADER_SYNC_HEADER_EN.
- Defined: SEND emits 0xA5 as byte 0, followed by the 4 data bytes (5 handshakes per word). word_count increments after the 5th byte.
- Undefined: exactly 4 bytes per word; no header logic.

Test Plan:
- Reset, enable=1, available=0 for 20 cycles -> o_read stays 0, tx_valid=0, busy=0, word_count=0.
- available=1, i_data=0x11223344, LSB_FIRST=1, tx_ready=1 -> o_read pulses 1 cycle; tx_valid rises 3 cycles later; bytes 0x44,0x33,0x22,0x11 on consecutive cycles; word_count=1.
- Same word with LSB_FIRST=0 and tx_ready toggling 1,0,0,1 -> bytes 0x11,0x22,0x33,0x44; tx_data held stable during ready-low cycles; no byte duplicated or lost.
- available held high, 3 words 0xA0000001..0xA0000003 queued -> exactly 3 o_read pulses, each separated by at least 1 low cycle; 12 bytes in order; word_count=3.
- Drop enable during byte 1 of a word -> remaining bytes still sent; no further o_read pulses while enable=0.
- Assert _mrst low during WAIT, then release -> all outputs at reset values the next cycle; operation resumes cleanly. With CHANNEL_UPLOADER_SYNC_HEADER_EN defined, the first byte is 0xA5.
